stack_mc_controller: RTL and testbench
======================================

# stack_mc_controller

Multi-cycle control unit and next-PC logic for the stack-based processor. It sits directly upstream of the PC register and drives that register's `next_pc` and `enable` inputs. It consumes the current `pc` and the memory read data. It holds the instruction register and sequences memory, stack and ALU operations through a Moore state machine. Datapath registers (A, B, MDR), the stack and the ALU live outside this block.

## Interface
- `ADDR_WIDTH`, default 5: width of PC, memory address and the instruction address field. The instruction is 3+ADDR_WIDTH bits wide: opcode in the top 3 bits, address in the low ADDR_WIDTH bits.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high.
- `pc`  in  ADDR_WIDTH: current PC register value.
- `mem_rdata`  in  3+ADDR_WIDTH: memory read data. Combinational from `mem_addr`.
- `tos_zero`  in  1: stack top-of-stack equals zero.
- `stack_empty`, `stack_full`  in  1 each: stack status flags.
- `pc_enable`  out  1: write strobe to the PC register.
- `next_pc`  out  ADDR_WIDTH: value the PC loads.
- `mem_addr`  out  ADDR_WIDTH: memory address.
- `mem_read`, `mem_write`  out  1 each: memory strobes. Write data is the TOS, supplied by the datapath.
- `mdr_load`  out  1: capture `mem_rdata` into the MDR.
- `stack_push`, `stack_pop`  out  1 each: stack strobes.
- `push_src`  out  1: stack push data select. 0 = MDR, 1 = ALU result.
- `a_load`, `b_load`  out  1 each: capture TOS into A or B.
- `alu_op`  out  2: 00 = B+A, 01 = B−A, 10 = B&A, 11 = ~A.
- `halted`  out  1: sticky stack-error indication.

## Operation
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 NOT
  - 100 PUSH addr, 101 POP addr
  - 110 JMP addr, 111 JZ addr
- `alu_op` equals IR[opcode][1:0] at all times.
- States: FETCH, DECODE, POP_A, POP_B, ALU_PUSH, MEM_RD, PUSH_MEM, POP_ST, HALT.
- All outputs are decoded from the state and IR only (Moore). Every strobe not listed for a state is 0.
- FETCH:
  - Outputs: `mem_addr`=pc, `mem_read`=1, `pc_enable`=1, `next_pc`=pc+1 (mod 2^ADDR_WIDTH).
  - IR loads `mem_rdata`.
  - Next state: DECODE.
- DECODE:
  - JMP: `pc_enable`=1, `next_pc`=IR addr; go to FETCH.
  - JZ:
    - If `stack_empty`, go to HALT.
    - Otherwise `pc_enable`=`tos_zero`, `next_pc`=IR addr; go to FETCH.
    - JZ does not pop.
  - ADD/SUB/AND/NOT: go to POP_A.
  - PUSH: go to MEM_RD.
  - POP: go to POP_ST.
- POP_A: if `stack_empty`, go to HALT with no strobes. Otherwise `a_load`=1, `stack_pop`=1. Next state is ALU_PUSH for NOT, else POP_B.
- POP_B: same empty check. Otherwise `b_load`=1, `stack_pop`=1; go to ALU_PUSH.
- ALU_PUSH: `stack_push`=1, `push_src`=1; go to FETCH. Cannot overflow because at least one entry was just popped.
- MEM_RD: `mem_addr`=IR addr, `mem_read`=1, `mdr_load`=1; go to PUSH_MEM.
- PUSH_MEM: if `stack_full`, go to HALT with no strobes. Otherwise `stack_push`=1, `push_src`=0; go to FETCH.
- POP_ST: if `stack_empty`, go to HALT. Otherwise `mem_addr`=IR addr, `mem_write`=1, `stack_pop`=1; go to FETCH.
- HALT:
  - `halted`=1.
  - All strobes are 0.
  - `next_pc`=pc.
  - Remains in HALT until reset.
- `next_pc` when `pc_enable`=0 equals pc.
- `mem_addr` outside the states above equals pc.
- `push_src` and `alu_op` are don't-care when unused, but must be stable, with no X.

## Timing
- Reset, asynchronous and immediate:
  - State = FETCH, IR = 0.
  - Outputs settle to FETCH values: `mem_read`=1, `pc_enable`=1, `next_pc`=pc+1, `mem_addr`=pc.
  - All other outputs 0, including `halted`.
  - The PC register is held at 0 by the same reset.
- First fetch occurs on the first rising edge after reset deasserts.
- Instruction latencies, counted from FETCH entry to the next FETCH entry:
  - ADD/SUB/AND: 5 cycles
  - NOT: 4
  - PUSH: 4
  - POP: 3
  - JMP: 2
  - JZ: 2, taken or not
- PC wrap: pc = 2^ADDR_WIDTH−1 in FETCH gives `next_pc` = 0.
- Stack flags are sampled in the state performing the access. The error check overrides the strobes in that same cycle, so no partial pop or push is issued.
- Reset asserted mid-instruction aborts it. No strobe survives past reset assertion except the FETCH values.

## Test plan
- Program at address 0: PUSH 20, PUSH 21, ADD, POP 22, with mem[20]=3, mem[21]=4.
  - Required: mem[22]=7.
  - Required: stack empty.
  - Required: PC=4 after 4+4+5+3=16 cycles.
- SUB with mem[20]=9 pushed, then mem[21]=2 pushed.
  - Required: pushed result 7 (B−A).
  - Required: `alu_op`=01 in POP_A, POP_B and ALU_PUSH.
- Branches:
  - JZ 10 with TOS=0: `pc_enable`=1 and `next_pc`=10 in DECODE.
  - JZ 10 with TOS=5: `pc_enable`=0 in DECODE; PC advances sequentially.
  - JMP 31: PC=31.
  - A FETCH at PC=31 yields `next_pc`=0.
- Stack error cases:
  - ADD with one entry: POP_A pops, POP_B sees empty, HALT with no second pop; `halted`=1 and stays 1.
  - PUSH with `stack_full`: HALT with no push.
- Reset asserted during POP_B:
  - All strobes drop immediately.
  - State FETCH, `halted`=0.
  - The first fetch after release reads address 0.

Source files
------------

// File: rtl/stack_mc_controller.sv
// Multi-cycle control unit and next-PC logic for the stack processor.
// Holds the IR and sequences memory, stack and ALU strobes (Moore FSM).
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   pc                   current PC register value
//   mem_rdata            memory read data (combinational from mem_addr)
//   tos_zero             top-of-stack equals zero
//   stack_empty/full     stack status flags
//   pc_enable, next_pc   PC register write strobe and load value
//   mem_addr             memory address
//   mem_read/mem_write   memory strobes (write data is TOS)
//   mdr_load             capture mem_rdata into the MDR
//   stack_push/pop       stack strobes
//   push_src             push data select: 0 = MDR, 1 = ALU result
//   a_load, b_load       capture TOS into A / B
//   alu_op               00 B+A, 01 B-A, 10 B&A, 11 ~A
//   halted               sticky stack-error indication
module stack_mc_controller #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH+2:0] mem_rdata,
  input  logic                  tos_zero,
  input  logic                  stack_empty,
  input  logic                  stack_full,
  output logic                  pc_enable,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mdr_load,
  output logic                  stack_push,
  output logic                  stack_pop,
  output logic                  push_src,
  output logic                  a_load,
  output logic                  b_load,
  output logic [1:0]            alu_op,
  output logic                  halted
);

  localparam int IW = ADDR_WIDTH + 3;

  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_POP_A,
    S_POP_B,
    S_ALU_PUSH,
    S_MEM_RD,
    S_PUSH_MEM,
    S_POP_ST,
    S_HALT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_ir;
  logic [2:0]            w_op;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_op   = r_ir[IW-1 -: 3];
  assign w_addr = r_ir[ADDR_WIDTH-1:0];

  // ALU op is the low two opcode bits; harmless when the ALU is unused.
  assign alu_op = w_op[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_ir <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_enable  = 1'b0;
    next_pc    = pc;
    mem_addr   = pc;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mdr_load   = 1'b0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    push_src   = 1'b0;
    a_load     = 1'b0;
    b_load     = 1'b0;
    halted     = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        pc_enable = 1'b1;
        next_pc   = pc + ADDR_WIDTH'(1);
        w_next    = S_DECODE;
      end

      S_DECODE: begin
        case (w_op)
          OP_JMP: begin
            pc_enable = 1'b1;
            next_pc   = w_addr;
            w_next    = S_FETCH;
          end
          OP_JZ: begin
            // Branch tests TOS without popping; an empty stack has no TOS.
            if (stack_empty) begin
              w_next = S_HALT;
            end else begin
              pc_enable = tos_zero;
              next_pc   = tos_zero ? w_addr : pc;
              w_next    = S_FETCH;
            end
          end
          OP_PUSH: w_next = S_MEM_RD;
          OP_POP:  w_next = S_POP_ST;
          default: w_next = S_POP_A;
        endcase
      end

      S_POP_A: begin
        if (stack_empty) begin
          w_next = S_HALT;
        end else begin
          a_load    = 1'b1;
          stack_pop = 1'b1;
          w_next    = (w_op == OP_NOT) ? S_ALU_PUSH : S_POP_B;
        end
      end

      S_POP_B: begin
        if (stack_empty) begin
          w_next = S_HALT;
        end else begin
          b_load    = 1'b1;
          stack_pop = 1'b1;
          w_next    = S_ALU_PUSH;
        end
      end

      S_ALU_PUSH: begin
        stack_push = 1'b1;
        push_src   = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEM_RD: begin
        mem_addr = w_addr;
        mem_read = 1'b1;
        mdr_load = 1'b1;
        w_next   = S_PUSH_MEM;
      end

      S_PUSH_MEM: begin
        if (stack_full) begin
          w_next = S_HALT;
        end else begin
          stack_push = 1'b1;
          w_next     = S_FETCH;
        end
      end

      S_POP_ST: begin
        if (stack_empty) begin
          w_next = S_HALT;
        end else begin
          mem_addr  = w_addr;
          mem_write = 1'b1;
          stack_pop = 1'b1;
          w_next    = S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_stack_mc_controller.sv
// Bench for stack_mc_controller: PC register, memory and 4-deep stack
// around the controller; program vectors plus corner-case sequences.
module tb_stack_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pc;
  logic [7:0] mem_rdata;
  logic       tos_zero, stack_empty, stack_full;
  logic       pc_enable;
  logic [4:0] next_pc, mem_addr;
  logic       mem_read, mem_write, mdr_load;
  logic       stack_push, stack_pop, push_src;
  logic       a_load, b_load;
  logic [1:0] alu_op;
  logic       halted;

  always #5 clk = ~clk;

  stack_mc_controller #(.ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .mem_rdata  (mem_rdata),
    .tos_zero   (tos_zero),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .pc_enable  (pc_enable),
    .next_pc    (next_pc),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mdr_load   (mdr_load),
    .stack_push (stack_push),
    .stack_pop  (stack_pop),
    .push_src   (push_src),
    .a_load     (a_load),
    .b_load     (b_load),
    .alu_op     (alu_op),
    .halted     (halted)
  );

  // ---- environment: PC register, memory, stack, A/B/MDR, ALU ----
  logic [7:0] mem [32];
  logic [7:0] stk [4];
  logic [2:0] sp;
  logic [7:0] a_r, b_r, mdr_r;
  logic [7:0] w_tos, w_alu, w_pd;
  int         bad_cnt;
  logic       ld_en;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;

  always_comb begin
    w_tos = 8'h00;
    if (sp != 3'd0) w_tos = stk[sp[1:0] - 2'd1];
  end

  always_comb begin
    case (alu_op)
      2'b00:   w_alu = b_r + a_r;
      2'b01:   w_alu = b_r - a_r;
      2'b10:   w_alu = b_r & a_r;
      default: w_alu = ~a_r;
    endcase
  end

  assign w_pd        = push_src ? w_alu : mdr_r;
  assign mem_rdata   = mem[mem_addr];
  assign stack_empty = (sp == 3'd0);
  assign stack_full  = (sp == 3'd4);
  assign tos_zero    = (w_tos == 8'h00);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= 5'd0;
      sp      <= 3'd0;
      bad_cnt <= 0;
    end else begin
      if (pc_enable) pc <= next_pc;
      if (mdr_load) mdr_r <= mem_rdata;
      if (a_load) a_r <= w_tos;
      if (b_load) b_r <= w_tos;
      if (stack_push && stack_pop) begin
        bad_cnt <= bad_cnt + 1;
      end else if (stack_push) begin
        if (sp == 3'd4) bad_cnt <= bad_cnt + 1;
        else begin
          stk[sp[1:0]] <= w_pd;
          sp <= sp + 3'd1;
        end
      end else if (stack_pop) begin
        if (sp == 3'd0) bad_cnt <= bad_cnt + 1;
        else sp <= sp - 3'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_write && !reset) mem[mem_addr] <= w_tos;
  end

  // ---- checking ----
  int n_pass = 0;
  int n_tot  = 0;
  int cyc;
  int last_f;
  bit have_last;
  int lat_q [$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One cycle; on each FETCH entry the scoreboard pops the expected
  // latency of the instruction that just finished.
  task automatic tick();
    int e;
    @(negedge clk);
    cyc++;
    if (!reset && mem_read && pc_enable) begin
      if (have_last && lat_q.size() > 0) begin
        e = lat_q.pop_front();
        check($sformatf("latency@%0d", cyc), 32'(cyc - last_f), 32'(e));
      end
      have_last = 1'b1;
      last_f = cyc;
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [0:7][7:0] prog,
                          input logic [7:0] m20, input logic [7:0] m21);
    logic [7:0] d;
    reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      if (a < 8) d = prog[a];
      else if (a == 20) d = m20;
      else if (a == 21) d = m21;
      else d = 8'h00;
      load(5'(a), d);
    end
    ld_en = 1'b0;
    lat_q.delete();
    have_last = 1'b0;
    cyc = 0;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [0:7][7:0] prog;
    logic [7:0]      m20;
    logic [7:0]      m21;
    logic [0:3][3:0] lat;
    int              ncyc;
    logic [4:0]      epc;
    logic [4:0]      enpc;
    logic [2:0]      esp;
    logic [7:0]      etos;
    logic [7:0]      em22;
    logic            ehalt;
  } vec_t;

  vec_t v [11];

  initial begin
    reset = 1'b1;
    ld_en = 1'b0;
    ld_addr = 5'd0;
    ld_data = 8'h00;

    // PUSH20=94 PUSH21=95 ADD=00 SUB=20 AND=40 NOT=60 POP22=B6
    // JMP31=DF JZ5=E5 JZ10=EA
    v[0]  = '{{8'h94,8'h95,8'h00,8'hB6,8'h00,8'h00,8'h00,8'h00}, 8'd3, 8'd4,
              {4'd4,4'd4,4'd5,4'd3}, 17, 5'd4, 5'd5, 3'd0, 8'h00, 8'd7, 1'b0};
    v[1]  = '{{8'h94,8'h95,8'h20,8'hB6,8'h00,8'h00,8'h00,8'h00}, 8'd9, 8'd2,
              {4'd4,4'd4,4'd5,4'd3}, 17, 5'd4, 5'd5, 3'd0, 8'h00, 8'd7, 1'b0};
    v[2]  = '{{8'h94,8'h95,8'h40,8'hB6,8'h00,8'h00,8'h00,8'h00}, 8'd12, 8'd10,
              {4'd4,4'd4,4'd5,4'd3}, 17, 5'd4, 5'd5, 3'd0, 8'h00, 8'd8, 1'b0};
    v[3]  = '{{8'h94,8'h60,8'hB6,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'h0F, 8'd0,
              {4'd4,4'd4,4'd3,4'd0}, 12, 5'd3, 5'd4, 3'd0, 8'h00, 8'hF0, 1'b0};
    v[4]  = '{{8'hDF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'd0, 8'd0,
              {4'd2,4'd0,4'd0,4'd0}, 3, 5'd31, 5'd0, 3'd0, 8'h00, 8'd0, 1'b0};
    v[5]  = '{{8'h94,8'hE5,8'h95,8'h00,8'h00,8'h94,8'h00,8'h00}, 8'd0, 8'h55,
              {4'd4,4'd2,4'd4,4'd0}, 11, 5'd6, 5'd7, 3'd2, 8'h00, 8'd0, 1'b0};
    v[6]  = '{{8'h94,8'hE5,8'h95,8'h00,8'h00,8'h94,8'h00,8'h00}, 8'd5, 8'h55,
              {4'd4,4'd2,4'd4,4'd0}, 11, 5'd3, 5'd4, 3'd2, 8'h55, 8'd0, 1'b0};
    v[7]  = '{{8'h94,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'd3, 8'd0,
              {4'd4,4'd0,4'd0,4'd0}, 12, 5'd2, 5'd2, 3'd0, 8'h00, 8'd0, 1'b1};
    v[8]  = '{{8'h94,8'h94,8'h94,8'h94,8'h94,8'h00,8'h00,8'h00}, 8'd1, 8'd0,
              {4'd4,4'd4,4'd4,4'd4}, 24, 5'd5, 5'd5, 3'd4, 8'h01, 8'd0, 1'b1};
    v[9]  = '{{8'hB6,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'd0, 8'd0,
              {4'd0,4'd0,4'd0,4'd0}, 6, 5'd1, 5'd1, 3'd0, 8'h00, 8'd0, 1'b1};
    v[10] = '{{8'hE5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'd0, 8'd0,
              {4'd0,4'd0,4'd0,4'd0}, 5, 5'd1, 5'd1, 3'd0, 8'h00, 8'd0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      do_reset(v[i].prog, v[i].m20, v[i].m21);
      for (int k = 0; k < 4; k++)
        if (v[i].lat[k] != 4'd0) lat_q.push_back(int'(v[i].lat[k]));
      repeat (v[i].ncyc) tick();
      check($sformatf("v%0d_latq", i), 32'(lat_q.size()), 32'd0);
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(v[i].epc));
      check($sformatf("v%0d_next_pc", i), 32'(next_pc), 32'(v[i].enpc));
      check($sformatf("v%0d_sp", i), 32'(sp), 32'(v[i].esp));
      check($sformatf("v%0d_tos", i), 32'(w_tos), 32'(v[i].etos));
      check($sformatf("v%0d_mem22", i), 32'(mem[22]), 32'(v[i].em22));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(v[i].ehalt));
      check($sformatf("v%0d_badacc", i), 32'(bad_cnt), 32'd0);
    end

    // SUB: alu_op held at 01 through the pop/pop/push sequence.
    do_reset({8'h94,8'h95,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'd9, 8'd2);
    repeat (11) tick();
    check("sub_popa_aluop", 32'(alu_op), 32'd1);
    check("sub_popa_aload", 32'(a_load), 32'd1);
    tick();
    check("sub_popb_aluop", 32'(alu_op), 32'd1);
    tick();
    check("sub_push_aluop", 32'(alu_op), 32'd1);
    check("sub_push_src", 32'(push_src), 32'd1);
    check("sub_push_strobe", 32'(stack_push), 32'd1);
    tick();
    check("sub_result", 32'(w_tos), 32'd7);
    check("sub_sp", 32'(sp), 32'd1);

    // JZ 10 taken and not taken, observed in DECODE.
    do_reset({8'h94,8'hEA,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'd0, 8'd0);
    repeat (6) tick();
    check("jz_t_pc_en", 32'(pc_enable), 32'd1);
    check("jz_t_next_pc", 32'(next_pc), 32'd10);
    tick();
    check("jz_t_fetch_addr", 32'(mem_addr), 32'd10);
    do_reset({8'h94,8'hEA,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'd5, 8'd0);
    repeat (6) tick();
    check("jz_nt_pc_en", 32'(pc_enable), 32'd0);
    check("jz_nt_next_pc", 32'(next_pc), 32'd2);
    tick();
    check("jz_nt_fetch_addr", 32'(mem_addr), 32'd2);

    // Reset asserted while in POP_B of an ADD.
    do_reset({8'h94,8'h95,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'd3, 8'd4);
    repeat (12) tick();
    check("rst_in_popb_bload", 32'(b_load), 32'd1);
    check("rst_in_popb_pop", 32'(stack_pop), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_strobes",
          32'({b_load, a_load, stack_pop, stack_push, mem_write, mdr_load,
               push_src}), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fetch", 32'({mem_read, pc_enable}), 32'd3);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_next_pc", 32'(next_pc), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    have_last = 1'b0;
    cyc = 0;
    tick();
    check("post_rst_addr", 32'(mem_addr), 32'd0);
    check("post_rst_read", 32'(mem_read), 32'd1);
    repeat (4) tick();
    check("post_rst_pc", 32'(pc), 32'd1);
    check("post_rst_sp", 32'(sp), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
